// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// The optional ACCESS watchdog is enabled with the APB_MASTER_TIMEOUT_EN macro.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_e;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    // Byte strobes driven on the bus: reads never carry strobes.
    function automatic logic [APB_STRB_W-1:0] apb_req_strb(
        input logic                  is_write,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_STRB_W-1:0] res;
        if (is_write) begin
            res = strb;
        end else begin
            res = {APB_STRB_W{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog for the APB master bridge. Counts stalled ACCESS
// cycles and flags when the last permitted stalled cycle is reached.
// Used by apb_master_bridge only when APB_MASTER_TIMEOUT_EN is defined.
module apb_watchdog #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic p_clk,
    input  logic p_resetn,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] LastCount = CntW'(TimeoutCycles - 32'd1);

    logic [CntW-1:0] r_count;

    // Stall counter: cleared before ACCESS starts, saturates at the terminal count.
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            r_count <= {CntW{1'b0}};
        end else if (i_clear) begin
            r_count <= {CntW{1'b0}};
        end else if (i_count_en && (r_count != LastCount)) begin
            r_count <= r_count + CntW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LastCount);

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 initiator: turns single valid/ready commands into SETUP/ACCESS
// transfers and returns a held response. Define APB_MASTER_TIMEOUT_EN to
// abort ACCESS phases that stall for TimeoutCycles cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned AddrBits      = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                  p_clk,
    input  logic                  p_resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [AddrBits-1:0]   cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    input  logic [APB_STRB_W-1:0] cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [AddrBits-1:0]   p_addr,
    output logic                  p_sel,
    output logic                  p_enable,
    output logic                  p_write,
    output logic [APB_DATA_W-1:0] p_wdata,
    output logic [APB_STRB_W-1:0] p_strb,
    input  logic [APB_DATA_W-1:0] p_rdata,
    input  logic                  p_ready,
    input  logic                  p_slverr
);

    apb_master_state_e     r_state;
    logic                  r_p_sel;
    logic                  r_p_enable;
    logic                  r_p_write;
    logic [AddrBits-1:0]   r_p_addr;
    logic [APB_DATA_W-1:0] r_p_wdata;
    logic [APB_STRB_W-1:0] r_p_strb;
    logic [APB_DATA_W-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_wdog_clear;
    logic w_wdog_count_en;
    logic w_wdog_expired;
    logic r_rsp_timeout;

    // The counter restarts while in SETUP so it reads zero on ACCESS entry.
    assign w_wdog_clear    = (r_state == SETUP);
    assign w_wdog_count_en = (r_state == ACCESS) && !p_ready;

    apb_watchdog #(
        .TimeoutCycles (TimeoutCycles)
    ) u_watchdog (
        .p_clk      (p_clk),
        .p_resetn   (p_resetn),
        .i_clear    (w_wdog_clear),
        .i_count_en (w_wdog_count_en),
        .o_expired  (w_wdog_expired)
    );

    assign rsp_timeout = r_rsp_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TimeoutCycles >= 32'd2);
    assign rsp_timeout          = 1'b0;
`endif

    // Transfer FSM with registered APB request and response fields.
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            r_state     <= IDLE;
            r_p_sel     <= 1'b0;
            r_p_enable  <= 1'b0;
            r_p_write   <= 1'b0;
            r_p_addr    <= {AddrBits{1'b0}};
            r_p_wdata   <= {APB_DATA_W{1'b0}};
            r_p_strb    <= {APB_STRB_W{1'b0}};
            r_rsp_rdata <= {APB_DATA_W{1'b0}};
            r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_state    <= SETUP;
                        r_p_sel    <= 1'b1;
                        r_p_enable <= 1'b0;
                        r_p_write  <= cmd_write;
                        r_p_addr   <= cmd_addr;
                        r_p_wdata  <= cmd_wdata;
                        r_p_strb   <= apb_req_strb(cmd_write, cmd_strb);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETUP: begin
                    r_state    <= ACCESS;
                    r_p_enable <= 1'b1;
                end
                ACCESS: begin
                    if (p_ready) begin
                        r_state     <= RESP;
                        r_p_sel     <= 1'b0;
                        r_p_enable  <= 1'b0;
                        r_rsp_rdata <= r_p_write ? {APB_DATA_W{1'b0}} : p_rdata;
                        r_rsp_err   <= p_slverr;
`ifdef APB_MASTER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
                    end else if (w_wdog_expired) begin
                        r_state       <= RESP;
                        r_p_sel       <= 1'b0;
                        r_p_enable    <= 1'b0;
                        r_rsp_rdata   <= {APB_DATA_W{1'b0}};
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
`endif
                    end else begin
                        r_state <= ACCESS;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= RESP;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_p_sel    <= 1'b0;
                    r_p_enable <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign p_sel     = r_p_sel;
    assign p_enable  = r_p_enable;
    assign p_write   = r_p_write;
    assign p_addr    = r_p_addr;
    assign p_wdata   = r_p_wdata;
    assign p_strb    = r_p_strb;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard testbench for apb_master_bridge: directed commands push their
// expected responses, a monitor pops and compares on each response handshake.
module tb_apb_master_bridge;

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_strb = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] p_addr;
    logic        p_sel;
    logic        p_enable;
    logic        p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic [31:0] p_rdata = 32'h0;
    logic        p_ready = 1'b0;
    logic        p_slverr = 1'b0;

    apb_master_bridge #(
        .AddrBits      (32),
        .TimeoutCycles (8)
    ) dut (
        .p_clk       (p_clk),
        .p_resetn    (p_resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .p_addr      (p_addr),
        .p_sel       (p_sel),
        .p_enable    (p_enable),
        .p_write     (p_write),
        .p_wdata     (p_wdata),
        .p_strb      (p_strb),
        .p_rdata     (p_rdata),
        .p_ready     (p_ready),
        .p_slverr    (p_slverr)
    );

    always #5 p_clk = ~p_clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t sb[$];
    int errors = 0;
    int checks = 0;

    // Slave model configuration and observations
    int          slv_wait = 0;
    int          slv_never = 0;
    int          slv_cnt = 0;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_err = 1'b0;
    int          setup_cnt = 0;
    int          access_cnt = 0;
    int          unstable = 0;
    logic [31:0] seen_addr = 32'h0;
    logic [31:0] seen_wdata = 32'h0;
    logic [3:0]  seen_strb = 4'h0;
    logic        seen_write = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // APB slave: waits slv_wait ACCESS cycles, drives junk while not ready.
    always @(negedge p_clk) begin
        if (p_sel && p_enable) begin
            access_cnt++;
            if (p_addr !== seen_addr || p_wdata !== seen_wdata ||
                p_strb !== seen_strb || p_write !== seen_write) begin
                unstable++;
            end
            if (slv_never == 0 && slv_cnt == slv_wait) begin
                p_ready  = 1'b1;
                p_rdata  = slv_rdata;
                p_slverr = slv_err;
            end else begin
                p_ready  = 1'b0;
                p_rdata  = 32'hBAD0BAD0;
                p_slverr = 1'b1;
            end
            slv_cnt++;
        end else begin
            if (p_sel) begin
                setup_cnt++;
                seen_addr  = p_addr;
                seen_wdata = p_wdata;
                seen_strb  = p_strb;
                seen_write = p_write;
            end
            p_ready  = 1'b0;
            p_rdata  = 32'h0;
            p_slverr = 1'b0;
            slv_cnt  = 0;
        end
    end

    // Response monitor: compares every handshaken response with the scoreboard.
    always @(negedge p_clk) begin
        rsp_t e;
        if (p_resetn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st);
        int k;
        @(posedge p_clk); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = st;
        k = 0;
        @(negedge p_clk);
        while (!cmd_ready && k < 50) begin
            @(negedge p_clk);
            k++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge p_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input int wt, input logic err,
                       input logic [31:0] rd, input int never, input int exp_lat,
                       input int exp_acc, input logic [3:0] exp_strb,
                       input logic [31:0] exp_rd, input logic exp_err, input logic exp_to);
        int lat;
        rsp_t e;
        slv_wait   = wt;
        slv_never  = never;
        slv_rdata  = rd;
        slv_err    = err;
        setup_cnt  = 0;
        access_cnt = 0;
        unstable   = 0;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.to    = exp_to;
        sb.push_back(e);
        issue(wr, addr, wd, st);
        lat = 1;
        @(negedge p_clk);
        while (!rsp_valid && lat < 400) begin
            @(negedge p_clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("setup_cycles", setup_cnt, 32'd1);
        chk("access_cycles", access_cnt, exp_acc);
        chk("p_strb", {28'd0, seen_strb}, {28'd0, exp_strb});
        chk("p_addr", seen_addr, addr);
        chk("p_write", {31'd0, seen_write}, {31'd0, wr});
        chk("req_stable", unstable, 32'd0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge p_clk);
            k++;
        end
        chk("sb_drain", sb.size(), 32'd0);
    endtask

    initial begin
        int seen;
        rsp_t e;

        // Reset state
        repeat (3) @(negedge p_clk);
        chk("rst_p_sel", {31'd0, p_sel}, 32'd0);
        chk("rst_p_enable", {31'd0, p_enable}, 32'd0);
        chk("rst_p_write", {31'd0, p_write}, 32'd0);
        chk("rst_p_addr", p_addr, 32'd0);
        chk("rst_p_wdata", p_wdata, 32'd0);
        chk("rst_p_strb", {28'd0, p_strb}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge p_clk); #1;
        p_resetn = 1'b1;

        // Write, 3 wait states: ACCESS lasts 4 cycles, response at cycle 6
        run(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 3, 1'b0, 32'h1111_1111, 0,
            6, 4, 4'hF, 32'h0, 1'b0, 1'b0);
        // Read, zero wait: strobes forced to 0, data at cycle 3
        run(1'b0, 32'h0000_0004, 32'h0, 4'hA, 0, 1'b0, 32'h1234_5678, 0,
            3, 1, 4'h0, 32'h1234_5678, 1'b0, 1'b0);
        // Write with slave error on the first ACCESS cycle
        run(1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'h5, 0, 1'b1, 32'h0, 0,
            3, 1, 4'h5, 32'h0, 1'b1, 1'b0);
        @(negedge p_clk);
        chk("idle_after_err", {31'd0, cmd_ready}, 32'd1);
        // Byte-serialised slave: three active strobes, three ACCESS cycles
        run(1'b1, 32'h0000_000C, 32'h0102_0304, 4'b1011, 2, 1'b0, 32'h0, 0,
            5, 3, 4'b1011, 32'h0, 1'b0, 1'b0);

        // Held response with a second command waiting
        @(posedge p_clk); #1;
        rsp_ready = 1'b0;
        run(1'b0, 32'h0000_0014, 32'h0, 4'hF, 1, 1'b0, 32'hCAFE_F00D, 0,
            4, 2, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
        @(posedge p_clk); #1;
        slv_wait  = 0;
        slv_err   = 1'b0;
        setup_cnt = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0020;
        cmd_wdata = 32'h55AA_55AA;
        cmd_strb  = 4'h3;
        for (int i = 0; i < 5; i++) begin
            @(negedge p_clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        chk("hold_no_setup", setup_cnt, 32'd0);
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.to    = 1'b0;
        sb.push_back(e);
        @(posedge p_clk); #1;
        rsp_ready = 1'b1;
        @(negedge p_clk);
        @(negedge p_clk);
        chk("idle_after_hold", {31'd0, cmd_ready}, 32'd1);
        @(posedge p_clk); #1;
        cmd_valid = 1'b0;
        @(negedge p_clk);
        chk("next_accept_sel", {31'd0, p_sel}, 32'd1);
        chk("next_accept_en", {31'd0, p_enable}, 32'd0);
        drain();

        // Asynchronous reset in the middle of ACCESS
        slv_never = 1;
        issue(1'b1, 32'h0000_0040, 32'h7777_7777, 4'hF);
        seen = 0;
        while (!p_enable && seen < 10) begin
            @(negedge p_clk);
            seen++;
        end
        chk("reached_access", {31'd0, p_enable}, 32'd1);
        #2;
        p_resetn = 1'b0;
        #1;
        chk("arst_p_sel", {31'd0, p_sel}, 32'd0);
        chk("arst_p_enable", {31'd0, p_enable}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge p_clk); #1;
        @(posedge p_clk); #1;
        p_resetn = 1'b1;
        @(negedge p_clk);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge p_clk);
            if (rsp_valid || p_sel) seen++;
        end
        chk("arst_no_response", seen, 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never ready: abort after 8 ACCESS cycles
        run(1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 1'b0, 32'hFFFF_FFFF, 1,
            10, 8, 4'h0, 32'h0, 1'b1, 1'b1);
        // Ready on the 8th ACCESS cycle wins over the watchdog
        run(1'b0, 32'h0000_0034, 32'h0, 4'h0, 7, 1'b0, 32'h0BAD_F00D, 0,
            10, 8, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0);
`endif

        drain();
        repeat (2) @(negedge p_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that converts single-transfer requests from a local valid/ready command port into APB4 SETUP/ACCESS sequences. Responses are returned on a held response port. It is the bus-side counterpart to the team's APB slaves. It tolerates arbitrary slave wait states, including multi-cycle byte-serialised slaves, and reports slave errors.

## Interface
- AddrBits, 32, width of cmd_addr / p_addr
- TimeoutCycles, 256, max ACCESS cycles before abort; used only with the watchdog macro; must be ≥2
- p_clk  in  1  APB clock
- p_resetn  in  1  reset p_resetn, asynchronous, active-low; clock p_clk
- cmd_valid  in  1  request present
- cmd_ready  out  1  request accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AddrBits  transfer address, passed through unmodified
- cmd_wdata  in  32  write data
- cmd_strb  in  4  write byte strobes
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- p_addr  out  AddrBits; p_sel  out  1; p_enable  out  1; p_write  out  1; p_wdata  out  32; p_strb  out  4  APB request
- p_rdata  in  32; p_ready  in  1; p_slverr  in  1  APB completion

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. When cmd_valid, latch write/addr/wdata/strb and go to SETUP. For reads, p_strb is latched as 4'b0000, regardless of cmd_strb.
- SETUP: p_sel=1, p_enable=0, for exactly one cycle, then go to ACCESS.
- ACCESS: p_sel=1, p_enable=1. Stay while p_ready=0. On p_ready=1:
  - capture rsp_rdata as p_rdata for reads and 0 for writes;
  - capture rsp_err as p_slverr;
  - go to RESP.
- p_slverr and p_rdata are sampled only in ACCESS with p_ready=1; ignored otherwise.
- RESP: p_sel=0, p_enable=0, rsp_valid=1, and the response fields are held. When rsp_ready, go to IDLE. No new command is accepted in RESP.
- p_addr, p_write, p_wdata, p_strb: stable from SETUP through ACCESS. They keep their last values in IDLE and RESP (no toggling when not selected).
- cmd_ready=0 in every state other than IDLE.
- Outputs are registered, except cmd_ready and rsp_valid, which decode from state.

## Timing
- Reset values:
  - state IDLE;
  - p_sel, p_enable, p_write, p_addr, p_wdata, p_strb all 0;
  - rsp_rdata, rsp_err, rsp_timeout all 0;
  - cmd_ready=1, rsp_valid=0.
- Latency, with accept at cycle 0: SETUP at cycle 1, ACCESS at cycle 2. If p_ready is seen at cycle 2+W, rsp_valid rises at cycle 3+W.
- Minimum command-to-command spacing is 4 cycles, with rsp_ready tied high.
- A byte-serialised slave (one ACCESS cycle per active strobe byte) needs no special handling; the bridge simply waits for p_ready.
- Async reset during SETUP/ACCESS: p_sel/p_enable drop immediately, the transfer is lost, and no response is produced.
- rsp_ready asserted outside RESP is ignored.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with p_ready=0. When it reaches TimeoutCycles-1 with p_ready still 0:
  - next cycle go to RESP;
  - p_sel/p_enable drop;
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- If p_ready arrives on the terminal cycle, it wins: normal completion.
- Undefined: ACCESS waits indefinitely, rsp_timeout is tied 0, and no counter logic is present.

## Structure
- Package apb_pkg:
  - typedef enum logic [1:0] apb_master_state_e {IDLE, SETUP, ACCESS, RESP};
  - constants APB_DATA_W=32 and APB_STRB_W=4.
- Sub-module apb_watchdog, instantiated only under APB_MASTER_TIMEOUT_EN:
  - inputs: clear, count enable;
  - output: expired;
  - parameter: TimeoutCycles.

## Test plan
- Write 0x0000_0010 / 0xDEADBEEF / strb 4'b1111, slave ready after 3 wait states:
  - SETUP for 1 cycle, ACCESS for 4 cycles, p_strb=4'hF;
  - rsp_valid with rsp_err=0, rsp_rdata=0.
- Read 0x0000_0004, p_rdata=0x12345678 with zero wait:
  - p_strb=0, rsp_rdata=0x12345678 at cycle 3 after accept.
- Write with p_ready=1 and p_slverr=1 in the first ACCESS cycle:
  - rsp_err=1, rsp_timeout=0, and the bridge returns to IDLE.
- Response held with rsp_ready=0 for 5 cycles:
  - rsp_valid and fields stable, cmd_ready=0, a second cmd_valid is not accepted;
  - when rsp_ready=1, the bridge goes to IDLE and the next command is accepted the following cycle.
- p_resetn pulsed low mid-ACCESS:
  - p_sel/p_enable go 0 asynchronously, rsp_valid stays 0;
  - after release, cmd_ready=1.
- With APB_MASTER_TIMEOUT_EN and TimeoutCycles=8, slave never ready:
  - abort after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1;
  - repeat with p_ready on the 8th cycle: normal completion.
